// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl
// Adds two packed-BCD operands one digit per clock, least-significant digit
// first, through a single shared BCD digit adder, with a start/busy/done
// handshake.
// Optional feature macro: BCD_SERIAL_SUBTRACT_EN adds a `sub` input that
// turns the operation into a - b (nines' complement of B plus a forced
// initial carry).
module bcd_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
`ifdef BCD_SERIAL_SUBTRACT_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  err
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [W-1:0]     a_sh_r;
    logic [W-1:0]     b_sh_r;
    logic             carry_r;
    logic [IDX_W-1:0] idx_r;

    logic             sub_s;
    logic [3:0]       y_eff_s;
    logic [4:0]       add_s;
    logic             digit_err_s;
    logic             load_carry_s;

`ifdef BCD_SERIAL_SUBTRACT_EN
    logic             sub_r;
    assign sub_s = sub_r;
`else
    assign sub_s = 1'b0;
`endif

    // One BCD digit add: returns {carry, digit}. Digits above 9 still go
    // through the +6 correction so invalid inputs give a deterministic result.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] x,
                                                 input logic [3:0] y,
                                                 input logic       ci);
        logic [5:0] s;
        s = {2'b00, x} + {2'b00, y} + {5'b00000, ci};
        if (s > 6'd9) begin
            s = s + 6'd6;
            return {1'b1, s[3:0]};
        end else begin
            return {1'b0, s[3:0]};
        end
    endfunction

    // Current-digit datapath: optional nines' complement of B, digit add,
    // invalid-digit detection on the original operand digits, and the
    // carry value to seed at an accepted start.
    always_comb begin
        y_eff_s      = b_sh_r[3:0];
        add_s        = 5'd0;
        digit_err_s  = 1'b0;
        load_carry_s = cin;
        if (sub_s) begin
            y_eff_s = 4'd9 - b_sh_r[3:0];
        end else begin
            y_eff_s = b_sh_r[3:0];
        end
        add_s       = bcd_digit_add(a_sh_r[3:0], y_eff_s, carry_r);
        digit_err_s = (a_sh_r[3:0] > 4'd9) || (b_sh_r[3:0] > 4'd9);
`ifdef BCD_SERIAL_SUBTRACT_EN
        if (sub) begin
            load_carry_s = 1'b1;
        end else begin
            load_carry_s = cin;
        end
`endif
    end

    // Sequencer FSM with all outputs registered; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
`ifdef BCD_SERIAL_SUBTRACT_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= load_carry_s;
                        idx_r   <= '0;
                        err     <= 1'b0;
                        sum     <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_ADD;
`ifdef BCD_SERIAL_SUBTRACT_EN
                        sub_r   <= sub;
`endif
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADD: begin
                    sum[{idx_r, 2'b00} +: 4] <= add_s[3:0];
                    carry_r <= add_s[4];
                    err     <= err | digit_err_s;
                    a_sh_r  <= a_sh_r >> 4;
                    b_sh_r  <= b_sh_r >> 4;
                    if (idx_r == LAST_IDX) begin
                        cout    <= add_s[4];
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        idx_r   <= '0;
                        state_r <= ST_DONE;
                    end else begin
                        idx_r   <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
